// File: rtl/presubaddor_pipe.sv
// presubaddor_pipe: pre-adder, multiplier and post-op, with an optional
// accumulator and a fixed-latency result pipeline.
// The whole result, including the accumulator update, is formed in the
// acceptance cycle. Back-to-back ACCUMULATE samples therefore see each
// other's sums, with no forwarding hazard. The pipe registers only add latency.
module presubaddor_pipe #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [WIDTH-1:0]     d,
  input  logic                 sub,
  input  logic [1:0]           op,
  input  logic                 acc_clr,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid
);

  localparam int PW = 2 * WIDTH;
  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  logic [WIDTH-1:0] pre_d;
  logic             pre_sgn, b_sgn, c_sgn;
  logic [PW-1:0]    pre_x, b_x, cx;
  logic [PW-1:0]    prod_d;
  logic [PW-1:0]    acc_base;
  logic [PW-1:0]    acc_sum_d;
  logic [PW-1:0]    res_d;
  logic             acc_load;

  logic [PW-1:0]     acc_q;
  logic [PW-1:0]     res_q [STAGES];
  logic [STAGES-1:0] vld_q;

  // Datapath: pre-add, extend, multiply, post-op. Everything wraps modulo the field width.
  always_comb begin
    pre_d     = sub ? (d - a) : (d + a);
    pre_sgn   = (SIGNED != 0) && pre_d[WIDTH-1];
    b_sgn     = (SIGNED != 0) && b[WIDTH-1];
    c_sgn     = (SIGNED != 0) && c[WIDTH-1];
    pre_x     = {{WIDTH{pre_sgn}}, pre_d};
    b_x       = {{WIDTH{b_sgn}}, b};
    cx        = {{WIDTH{c_sgn}}, c};
    prod_d    = pre_x * b_x;
    acc_base  = acc_clr ? '0 : acc_q;
    acc_sum_d = acc_base + prod_d;
    acc_load  = in_valid && (op == 2'b11);
    case (op)
      OP_OR:   res_d = prod_d | cx;
      OP_XOR:  res_d = prod_d ^ cx;
      OP_ADD:  res_d = prod_d + cx;
      default: res_d = acc_sum_d;
    endcase
  end

  // Accumulator: loads on an accepted ACCUMULATE sample (clear-then-add when acc_clr), else clears on acc_clr alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (ce) begin
      if (acc_load) begin
        acc_q <= acc_sum_d;
      end else if (acc_clr) begin
        acc_q <= '0;
      end
    end
  end

  // Result pipe: data regs load only with valid data, so the last stage holds the last valid result over bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
      end
    end else if (ce) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        res_q[0] <= res_d;
      end
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          res_q[i] <= res_q[i-1];
        end
      end
    end
  end

  assign out       = res_q[STAGES-1];
  assign out_valid = vld_q[STAGES-1];

endmodule

// File: tb/tb_presubaddor_pipe.sv
// Directed bench for presubaddor_pipe.
// An unsigned instance and a signed instance share every input. The bench
// checks both against hand-computed values.
module tb_presubaddor_pipe;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        in_valid;
  logic [9:0]  a, b, c, d;
  logic        sub;
  logic [1:0]  op;
  logic        acc_clr;
  logic [19:0] out_u, out_s;
  logic        ov_u, ov_s;

  int n_vec;
  int n_miss;

  typedef struct packed {
    logic        sub;
    logic [1:0]  op;
    logic [9:0]  d;
    logic [9:0]  a;
    logic [9:0]  b;
    logic [9:0]  c;
    logic [19:0] exp_u;
    logic [19:0] exp_s;
  } vec_t;

  vec_t tbl [10];

  presubaddor_pipe #(.WIDTH(10), .STAGES(2), .SIGNED(0)) u_u (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d), .sub(sub), .op(op), .acc_clr(acc_clr),
    .out(out_u), .out_valid(ov_u)
  );

  presubaddor_pipe #(.WIDTH(10), .STAGES(2), .SIGNED(1)) u_s (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d), .sub(sub), .op(op), .acc_clr(acc_clr),
    .out(out_s), .out_valid(ov_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_both(input string nm, input logic [19:0] exp, input logic expv);
    chk({nm, "_out_u"}, out_u, exp);
    chk({nm, "_vld_u"}, {19'd0, ov_u}, {19'd0, expv});
    chk({nm, "_out_s"}, out_s, exp);
    chk({nm, "_vld_s"}, {19'd0, ov_s}, {19'd0, expv});
  endtask

  task automatic drive(input logic s, input logic [1:0] o, input logic [9:0] dd,
                       input logic [9:0] aa, input logic [9:0] bb, input logic [9:0] cc,
                       input logic clr, input logic v);
    sub      = s;
    op       = o;
    d        = dd;
    a        = aa;
    b        = bb;
    c        = cc;
    acc_clr  = clr;
    in_valid = v;
  endtask

  logic [19:0] acc_exp [4];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    //            sub   op     d        a       b        c        unsigned     signed
    tbl[0] = '{1'b1, 2'd0, 10'd100,  10'd30, 10'd3,    10'd1,    20'd211,     20'd211};
    tbl[1] = '{1'b1, 2'd0, 10'd0,    10'd1,  10'd1023, 10'd0,    20'hFF801,   20'h00001};
    tbl[2] = '{1'b1, 2'd2, 10'd0,    10'd5,  10'd3,    10'd1,    20'h00BF2,   20'hFFFF2};
    tbl[3] = '{1'b0, 2'd1, 10'd10,   10'd5,  10'd4,    10'h3FF,  20'h003C3,   20'hFFFC3};
    tbl[4] = '{1'b0, 2'd2, 10'd1023, 10'd1,  10'd1023, 10'd1023, 20'h003FF,   20'hFFFFF};
    tbl[5] = '{1'b0, 2'd0, 10'd1023, 10'd0,  10'd1023, 10'd0,    20'hFF801,   20'h00001};
    tbl[6] = '{1'b1, 2'd2, 10'd512,  10'd0,  10'd512,  10'd0,    20'h40000,   20'h40000};
    tbl[7] = '{1'b0, 2'd1, 10'd3,    10'd4,  10'd2,    10'd5,    20'h0000B,   20'h0000B};
    tbl[8] = '{1'b0, 2'd2, 10'd1023, 10'd0,  10'd1023, 10'd1023, 20'hFFC00,   20'h00000};
    tbl[9] = '{1'b1, 2'd1, 10'd5,    10'd7,  10'd1,    10'd0,    20'h003FE,   20'hFFFFE};
    acc_exp[0] = 20'd2;
    acc_exp[1] = 20'd4;
    acc_exp[2] = 20'd6;
    acc_exp[3] = 20'd2;

    rst_n = 1'b0;
    ce    = 1'b1;
    drive(1'b0, 2'd0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk_both("reset", 20'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single isolated samples: result after two edges, then a bubble slot.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].sub, tbl[i].op, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].c, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_out_u", i), out_u, tbl[i].exp_u);
      chk($sformatf("vec%0d_out_s", i), out_s, tbl[i].exp_s);
      chk($sformatf("vec%0d_vld_u", i), {19'd0, ov_u}, 20'd1);
      chk($sformatf("vec%0d_vld_s", i), {19'd0, ov_s}, 20'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_bub_vld_u", i), {19'd0, ov_u}, 20'd0);
      chk($sformatf("vec%0d_bub_hold_u", i), out_u, tbl[i].exp_u);
      chk($sformatf("vec%0d_bub_hold_s", i), out_s, tbl[i].exp_s);
    end

    // Back-to-back accumulate. The 4th sample carries acc_clr (clear-then-add). c must be ignored.
    for (int t = 0; t < 6; t++) begin
      if (t >= 2) chk_both($sformatf("acc%0d", t - 2), acc_exp[t-2], 1'b1);
      if (t < 4) drive(1'b0, 2'd3, 10'd2, 10'd0, 10'd1, 10'd5, (t == 3), 1'b1);
      else       drive(1'b0, 2'd0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Stall with two samples in flight. Inputs driven during ce=0 must be ignored.
    drive(1'b0, 2'd2, 10'd4, 10'd1, 10'd3, 10'd7, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'd3, 10'd3, 10'd0, 10'd1, 10'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk_both("stall_pre", 20'd22, 1'b1);
    ce = 1'b0;
    drive(1'b0, 2'd3, 10'd50, 10'd0, 10'd2, 10'd0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_both($sformatf("stall%0d", k), 20'd22, 1'b1);
    end
    ce = 1'b1;
    drive(1'b0, 2'd3, 10'd1, 10'd0, 10'd1, 10'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk_both("stall_s1", 20'd5, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk_both("stall_s2", 20'd6, 1'b1);
    @(negedge clk);
    chk_both("stall_bub", 20'd6, 1'b0);

    // Reset asserted mid-cycle with work in flight. acc is 6 here.
    drive(1'b0, 2'd0, 10'd9, 10'd0, 10'd1, 10'd0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'd3, 10'd4, 10'd0, 10'd1, 10'd0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_both("rst_async", 20'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_both($sformatf("rst_idle%0d", k), 20'd0, 1'b0);
    end
    drive(1'b0, 2'd3, 10'd2, 10'd0, 10'd1, 10'd0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk_both("rst_acc", 20'd2, 1'b1);

    // acc_clr with no ACCUMULATE sample: acc goes to 0. The next accumulate shows only its own product.
    drive(1'b0, 2'd0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'd3, 10'd3, 10'd0, 10'd1, 10'd0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk_both("clr_only", 20'd3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
